// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M issue/writeback controller:
// funct3 encodings of the M extension and the controller state encoding.
package rv32m_pkg;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/rv32m_result_cache.sv
// Single-entry result cache for the RV32M issue controller. Remembers the
// last completed {funct3, rs1, rs2, result}; a lookup hits when the offered
// op matches exactly and the entry is valid. Only built when
// RV32M_RESULT_REUSE_EN is defined.
module rv32m_result_cache #(
  parameter int INPUT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_update,
  input  logic [2:0]             i_upd_funct3,
  input  logic [INPUT_WIDTH-1:0] i_upd_rs1,
  input  logic [INPUT_WIDTH-1:0] i_upd_rs2,
  input  logic [INPUT_WIDTH-1:0] i_upd_result,
  input  logic [2:0]             i_look_funct3,
  input  logic [INPUT_WIDTH-1:0] i_look_rs1,
  input  logic [INPUT_WIDTH-1:0] i_look_rs2,
  output logic                   o_hit,
  output logic [INPUT_WIDTH-1:0] o_result
);

  logic                   r_valid;
  logic [2:0]             r_funct3;
  logic [INPUT_WIDTH-1:0] r_rs1;
  logic [INPUT_WIDTH-1:0] r_rs2;
  logic [INPUT_WIDTH-1:0] r_result;

  // Entry storage: clear wins over update so a kill never leaves a stale hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_funct3 <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_result <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_update) begin
      r_valid  <= 1'b1;
      r_funct3 <= i_upd_funct3;
      r_rs1    <= i_upd_rs1;
      r_rs2    <= i_upd_rs2;
      r_result <= i_upd_result;
    end
  end

  assign o_hit    = r_valid && (r_funct3 == i_look_funct3) &&
                    (r_rs1 == i_look_rs1) && (r_rs2 == i_look_rs2);
  assign o_result = r_result;

endmodule

// File: rtl/rv32m_issue_ctrl.sv
// Issue and writeback controller in front of the RV32M mul/div unit.
// Latches one M-extension op, drives START/M_CNT/RS1/RS2 until READY,
// then holds the result on the writeback port until it is taken.
// Optional feature: RV32M_RESULT_REUSE_EN adds a one-entry result cache
// that lets an identical follow-up op bypass the unit.
//
// Handshakes: a transfer happens on a rising CLK edge where both valid and
// ready are high (ISSUE_VALID/ISSUE_READY, WB_VALID/WB_READY); valid never
// depends on ready, and WB_VALID/WB_DATA/WB_RD stay stable until taken.
module rv32m_issue_ctrl #(
  parameter int INPUT_WIDTH = 32,
  parameter int RD_WIDTH    = 5
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FLUSH,
  input  logic                   STALL_IN,
  input  logic                   ISSUE_VALID,
  output logic                   ISSUE_READY,
  input  logic [2:0]             ISSUE_FUNCT3,
  input  logic [INPUT_WIDTH-1:0] ISSUE_RS1,
  input  logic [INPUT_WIDTH-1:0] ISSUE_RS2,
  input  logic [RD_WIDTH-1:0]    ISSUE_RD,
  output logic                   M_START,
  output logic                   M_STALL,
  output logic [2:0]             M_CNT,
  output logic [INPUT_WIDTH-1:0] M_RS1,
  output logic [INPUT_WIDTH-1:0] M_RS2,
  input  logic [INPUT_WIDTH-1:0] M_OUT,
  input  logic                   M_READY,
  output logic                   WB_VALID,
  input  logic                   WB_READY,
  output logic [INPUT_WIDTH-1:0] WB_DATA,
  output logic [RD_WIDTH-1:0]    WB_RD,
  output logic                   BUSY,
  output logic [1:0]             DBG_STATE
);
  import rv32m_pkg::*;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_m_start;
  logic                   r_start_d1;
  logic [2:0]             r_funct3;
  logic [INPUT_WIDTH-1:0] r_rs1;
  logic [INPUT_WIDTH-1:0] r_rs2;
  logic [RD_WIDTH-1:0]    r_rd;
  logic                   r_wb_valid;
  logic [INPUT_WIDTH-1:0] r_wb_data;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_take;
  logic                   w_capture;
  logic                   w_hit_go;
  logic                   w_cache_hit;
  logic [INPUT_WIDTH-1:0] w_cache_data;

  assign ISSUE_READY = (r_state == IDLE) && !FLUSH && !STALL_IN;
  assign w_accept    = ISSUE_VALID && ISSUE_READY;
  // rd==0 ops are accepted but dropped: nothing to write back.
  assign w_take      = w_accept && (ISSUE_RD != '0);
  assign w_hit_go    = w_take && w_cache_hit;
  // READY counts only while START is actually up and the pipe is not stalled.
  assign w_capture   = (r_state == RUN) && r_m_start && M_READY && !STALL_IN && !FLUSH;

`ifdef RV32M_RESULT_REUSE_EN
  rv32m_result_cache #(.INPUT_WIDTH(INPUT_WIDTH)) u_cache (
    .clk           (CLK),
    .rst_n         (RST_N),
    .i_clear       (FLUSH),
    .i_update      (w_capture),
    .i_upd_funct3  (r_funct3),
    .i_upd_rs1     (r_rs1),
    .i_upd_rs2     (r_rs2),
    .i_upd_result  (M_OUT),
    .i_look_funct3 (ISSUE_FUNCT3),
    .i_look_rs1    (ISSUE_RS1),
    .i_look_rs2    (ISSUE_RS2),
    .o_hit         (w_cache_hit),
    .o_result      (w_cache_data)
  );
`else
  assign w_cache_hit  = 1'b0;
  assign w_cache_data = '0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; FLUSH always returns to IDLE from an active op.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = w_cache_hit ? HOLD : RUN;
      RUN:     if (FLUSH) w_state_nxt = IDLE;
               else if (w_capture) w_state_nxt = HOLD;
      HOLD:    if (FLUSH || WB_READY) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch and START generation. START may only rise after it has
  // been low for two full cycles, which the unit needs to rearm; in the
  // normal flow that gap is already there, after a flush it can add a cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_funct3   <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_m_start  <= 1'b0;
      r_start_d1 <= 1'b0;
    end else begin
      r_start_d1 <= r_m_start;
      if (w_take) begin
        r_funct3 <= ISSUE_FUNCT3;
        r_rs1    <= ISSUE_RS1;
        r_rs2    <= ISSUE_RS2;
        r_rd     <= ISSUE_RD;
      end
      if (w_state_nxt == RUN) r_m_start <= r_m_start || !r_start_d1;
      else                    r_m_start <= 1'b0;
    end
  end

  // Writeback register and pipeline stall request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wb_valid <= 1'b0;
      r_wb_data  <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (w_capture) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= M_OUT;
      end else if (w_hit_go) begin
        r_wb_valid <= 1'b1;
        r_wb_data  <= w_cache_data;
      end else if ((r_state == HOLD) && (WB_READY || FLUSH)) begin
        r_wb_valid <= 1'b0;
      end
      r_busy <= (w_state_nxt != IDLE);
    end
  end

  assign M_START   = r_m_start;
  assign M_STALL   = STALL_IN;
  assign M_CNT     = r_funct3;
  assign M_RS1     = r_rs1;
  assign M_RS2     = r_rs2;
  assign WB_VALID  = r_wb_valid;
  assign WB_DATA   = r_wb_data;
  assign WB_RD     = r_rd;
  assign BUSY      = r_busy;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_rv32m_issue_ctrl.sv
// Bench for rv32m_issue_ctrl: behavioural mul/div unit, directed scenarios,
// randomized ops, and a scoreboard monitor on the writeback port.
module tb_rv32m_issue_ctrl;
  import rv32m_pkg::*;

  localparam int W  = 32;
  localparam int RW = 5;

  logic          CLK, RST_N, FLUSH, STALL_IN, ISSUE_VALID, ISSUE_READY;
  logic [2:0]    ISSUE_FUNCT3;
  logic [W-1:0]  ISSUE_RS1, ISSUE_RS2;
  logic [RW-1:0] ISSUE_RD;
  logic          M_START, M_STALL, M_READY, WB_VALID, WB_READY, BUSY;
  logic [2:0]    M_CNT;
  logic [W-1:0]  M_RS1, M_RS2, M_OUT, WB_DATA;
  logic [RW-1:0] WB_RD;
  logic [1:0]    DBG_STATE;

  logic [W+RW-1:0] exp_q[$];
  int              n_checks;
  int              n_fail;
  int              unit_lat;
  logic            wb_force_low;
  logic            wb_rand;

  rv32m_issue_ctrl #(.INPUT_WIDTH(W), .RD_WIDTH(RW)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .STALL_IN(STALL_IN),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
    .ISSUE_FUNCT3(ISSUE_FUNCT3), .ISSUE_RS1(ISSUE_RS1), .ISSUE_RS2(ISSUE_RS2),
    .ISSUE_RD(ISSUE_RD), .M_START(M_START), .M_STALL(M_STALL), .M_CNT(M_CNT),
    .M_RS1(M_RS1), .M_RS2(M_RS2), .M_OUT(M_OUT), .M_READY(M_READY),
    .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_DATA(WB_DATA), .WB_RD(WB_RD),
    .BUSY(BUSY), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result, straight from the ISA rules.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] sa32, sb32, q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa32 = a;
    sb32 = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        q = sa32 / sb32;
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = sa32 % sb32;
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [RW-1:0] rd, input bit expect_wb);
    int guard;
    guard = 0;
    @(negedge CLK);
    ISSUE_VALID  = 1'b1;
    ISSUE_FUNCT3 = f;
    ISSUE_RS1    = a;
    ISSUE_RS2    = b;
    ISSUE_RD     = rd;
    while (!ISSUE_READY && guard < 500) begin
      @(negedge CLK);
      guard++;
    end
    if (!ISSUE_READY) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got ISSUE_READY=0 expected 1 within 500 cycles");
      ISSUE_VALID = 1'b0;
      return;
    end
    if (expect_wb && rd != 0) exp_q.push_back({rd, ref_op(f, a, b)});
    @(posedge CLK);
    @(negedge CLK);
    ISSUE_VALID = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || WB_VALID || !ISSUE_READY) && guard < 400) begin
      @(negedge CLK);
      #2;
      guard++;
    end
    check({name, "_drained"}, (exp_q.size() == 0) && !WB_VALID, 1);
  endtask

  // ---------------- behavioural mul/div unit ----------------
  initial begin
    int cnt;
    cnt     = 0;
    M_READY = 1'b0;
    M_OUT   = '0;
    forever begin
      @(negedge CLK);
      if (M_START === 1'b1) begin
        if (!M_READY) begin
          cnt++;
          if (cnt >= unit_lat) begin
            M_READY = 1'b1;
            M_OUT   = ref_op(M_CNT, M_RS1, M_RS2);
          end
        end
      end else begin
        cnt     = 0;
        M_READY = 1'b0;
        M_OUT   = $urandom;
      end
    end
  end

  // ---------------- writeback sink ----------------
  initial begin
    WB_READY = 1'b1;
    forever begin
      @(negedge CLK);
      WB_READY = wb_force_low ? 1'b0 : (wb_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic            prev_cap, prev_hold, prev_start;
    logic [W-1:0]    prev_data;
    logic [RW-1:0]   prev_rd;
    logic [W+RW-1:0] e;
    int              low_cnt;
    prev_cap = 0; prev_hold = 0; prev_start = 0; prev_data = '0; prev_rd = '0;
    low_cnt = 100;
    forever begin
      @(negedge CLK);
      #1;
      if (RST_N) begin
        if (prev_cap) begin
          check("cap_to_wb_valid", WB_VALID, 1);
          check("cap_start_drop", M_START, 0);
        end
        if (prev_hold) begin
          check("hold_wb_valid", WB_VALID, 1);
          check("hold_wb_data", WB_DATA, prev_data);
          check("hold_wb_rd", WB_RD, prev_rd);
        end
        if (M_START && !prev_start) check("start_low_gap_ge2", low_cnt >= 2, 1);
        low_cnt = M_START ? 0 : low_cnt + 1;
        if (WB_VALID && WB_READY) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_wb: got rd=%0d data=%0h expected no writeback", WB_RD, WB_DATA);
          end else begin
            e = exp_q.pop_front();
            check("wb_data", WB_DATA, e[W-1:0]);
            check("wb_rd", WB_RD, e[W+RW-1:W]);
          end
        end
        prev_cap   = M_START && M_READY && !STALL_IN && !FLUSH;
        prev_hold  = WB_VALID && !WB_READY && !FLUSH;
        prev_data  = WB_DATA;
        prev_rd    = WB_RD;
        prev_start = M_START;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]    f;
    logic [W-1:0]  a, b;
    logic [RW-1:0] rd;
    int            guard;
    n_checks = 0; n_fail = 0;
    RST_N = 1'b0; FLUSH = 1'b0; STALL_IN = 1'b0; ISSUE_VALID = 1'b0;
    ISSUE_FUNCT3 = '0; ISSUE_RS1 = '0; ISSUE_RS2 = '0; ISSUE_RD = '0;
    unit_lat = 2; wb_force_low = 1'b0; wb_rand = 1'b0;

    // reset values
    repeat (3) @(negedge CLK);
    #1;
    check("rst_m_start", M_START, 0);
    check("rst_m_cnt", M_CNT, 0);
    check("rst_m_rs1", M_RS1, 0);
    check("rst_m_rs2", M_RS2, 0);
    check("rst_wb_valid", WB_VALID, 0);
    check("rst_wb_data", WB_DATA, 0);
    check("rst_wb_rd", WB_RD, 0);
    check("rst_busy", BUSY, 0);
    check("rst_state", DBG_STATE, IDLE);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("post_rst_issue_ready", ISSUE_READY, 1);

    // MUL 8*8 -> 64 on rd 5
    issue(MUL, 32'd8, 32'd8, 5'd5, 1);
    wait_drain("mul_8x8");
    check("mul_issue_ready_back", ISSUE_READY, 1);

    // DIV 20/15 then REM 20/15
    issue(DIV, 32'd20, 32'd15, 5'd3, 1);
    issue(REM, 32'd20, 32'd15, 5'd3, 1);
    wait_drain("div_rem");

    // MULH 8,8 with writeback held off for 10 cycles
    wb_force_low = 1'b1;
    issue(MULH, 32'd8, 32'd8, 5'd7, 1);
    guard = 0;
    while (!WB_VALID && guard < 50) begin @(negedge CLK); #2; guard++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #2;
      check("hold_valid_stall", WB_VALID, 1);
      check("hold_data_zero", WB_DATA, 0);
      check("hold_busy", BUSY, 1);
      check("hold_issue_ready", ISSUE_READY, 0);
    end
    wb_force_low = 1'b0;
    wait_drain("mulh_hold");
    repeat (2) @(negedge CLK);
    #2;
    check("single_handshake", WB_VALID, 0);

    // DIVU 100/7 killed by FLUSH three cycles after accept
    unit_lat = 12;
    issue(DIVU, 32'd100, 32'd7, 5'd4, 0);
    @(negedge CLK);
    #1;
    check("flush_pre_start", M_START, 1);
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    check("flush_start_drop", M_START, 0);
    check("flush_busy_drop", BUSY, 0);
    @(negedge CLK);
    FLUSH = 1'b0;
    unit_lat = 2;
    issue(MUL, 32'd2, 32'd3, 5'd6, 1);
    wait_drain("post_flush_mul");

    // rd==0 op is swallowed
    issue(MUL, 32'd5, 32'd5, 5'd0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      #2;
      check("rd0_no_start", M_START, 0);
      check("rd0_no_wb", WB_VALID, 0);
    end

    // STALL_IN masks M_READY
    unit_lat = 1;
    issue(MUL, 32'd7, 32'd9, 5'd9, 1);
    STALL_IN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #2;
      check("stall_no_capture", WB_VALID, 0);
      check("stall_forwarded", M_STALL, 1);
    end
    STALL_IN = 1'b0;
    wait_drain("stall_mul");

    // MULHU 0xFFFFFFFF*2 twice: second may come from the result cache
    unit_lat = 3;
    issue(MULHU, 32'hFFFF_FFFF, 32'd2, 5'd10, 1);
    wait_drain("mulhu_first");
    issue(MULHU, 32'hFFFF_FFFF, 32'd2, 5'd11, 1);
    #1;
`ifdef RV32M_RESULT_REUSE_EN
    check("reuse_wb_t_plus_1", WB_VALID, 1);
    check("reuse_no_start", M_START, 0);
`else
    check("noreuse_start", M_START, 1);
`endif
    wait_drain("mulhu_second");

    // randomized traffic with writeback backpressure
    wb_rand = 1'b1;
    f = MUL; a = 0; b = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        f = 3'($urandom_range(0, 7));
        a = pick_operand();
        b = pick_operand();
      end
      rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      unit_lat = $urandom_range(1, 5);
      issue(f, a, b, rd, 1);
    end
    wb_rand = 1'b0;
    wait_drain("random");
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
